packet_arbiter_ctrl: RTL and testbench

Per-output-port packet arbiter and switch controller for the simple mesh XY switch. It selects one of `INPUT_N` input buffers holding a head flit and locks the output crossbar mux to that input until the packet's tail flit has been transferred downstream. It also generates the per-input ready (pop) signals and the output valid. One instance sits at each switch output, ahead of the output register.

---
 rtl/packet_arbiter_ctrl.sv | 132 +++++++++++++
 tb/tb_packet_arbiter_ctrl.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/packet_arbiter_ctrl.sv
// Packet arbiter and crossbar controller for one switch output port.
// Picks one input that is presenting a head flit and holds the output mux on
// that input until its tail flit has been transferred downstream.
// Optional feature macro: PACKET_ARB_ROUND_ROBIN_EN (round-robin arbitration;
// when undefined, fixed priority NORTH > SOUTH > EAST > WEST > RESOURCE, valid
// only for INPUT_N = 5).
module packet_arbiter_ctrl #(
  parameter int unsigned INPUT_N   = 5,
  parameter int unsigned FLIT_ID_W = 2,
  localparam int unsigned SEL_W    = (INPUT_N > 1) ? $clog2(INPUT_N) : 1
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [INPUT_N-1:0]             vld_i,
  input  logic [INPUT_N*FLIT_ID_W-1:0]   flit_id_i,
  input  logic                           out_rdy_i,
  output logic [SEL_W-1:0]               mux_in_sel_o,
  output logic [INPUT_N-1:0]             in_rdy_o,
  output logic                           out_vld_o,
  output logic                           locked_o
);

  typedef enum logic [0:0] {StIdle, StLocked} state_e;

  state_e             state_q, state_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [INPUT_N-1:0] cand;
  logic [SEL_W-1:0]   winner;
  logic               any_cand;
  logic               sel_vld;
  logic               sel_tail;
  logic               xfer;

  // An input competes only while it presents a flit with the HEAD bit set.
  always_comb begin
    cand = '0;
    for (int unsigned k = 0; k < INPUT_N; k++) begin
      cand[k] = vld_i[k] & flit_id_i[k*FLIT_ID_W + 1];
    end
  end

`ifdef PACKET_ARB_ROUND_ROBIN_EN
  logic [SEL_W-1:0] ptr_q, ptr_d;

  // Round-robin search: first candidate at or after ptr, wrapping at INPUT_N.
  always_comb begin
    int unsigned idx;
    idx      = 0;
    winner   = '0;
    any_cand = 1'b0;
    for (int unsigned i = 0; i < INPUT_N; i++) begin
      idx = (32'(ptr_q) + i) % INPUT_N;
      if (!any_cand && cand[idx]) begin
        any_cand = 1'b1;
        winner   = SEL_W'(idx);
      end
    end
  end
`else
  // Fixed priority: NORTH(3) > SOUTH(4) > EAST(2) > WEST(1) > RESOURCE(0).
  always_comb begin
    winner   = '0;
    any_cand = |cand;
    if (cand[3])      winner = SEL_W'(3);
    else if (cand[4]) winner = SEL_W'(4);
    else if (cand[2]) winner = SEL_W'(2);
    else if (cand[1]) winner = SEL_W'(1);
    else              winner = SEL_W'(0);
  end
`endif

  assign sel_vld  = vld_i[sel_q];
  assign sel_tail = flit_id_i[32'(sel_q)*FLIT_ID_W];
  assign xfer     = (state_q == StLocked) && sel_vld && out_rdy_i;

  // Next-state, lock register and per-input pop / output valid generation.
  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
`ifdef PACKET_ARB_ROUND_ROBIN_EN
    ptr_d     = ptr_q;
`endif
    out_vld_o = 1'b0;
    in_rdy_o  = '0;
    unique case (state_q)
      StIdle: begin
        if (any_cand) begin
          sel_d   = winner;
          state_d = StLocked;
        end
      end
      StLocked: begin
        // Only the locked input may pop; other inputs wait for the tail.
        out_vld_o       = sel_vld;
        in_rdy_o[sel_q] = out_rdy_i;
        if (xfer && sel_tail) begin
          state_d = StIdle;
`ifdef PACKET_ARB_ROUND_ROBIN_EN
          ptr_d = (sel_q == SEL_W'(INPUT_N - 1)) ? '0 : sel_q + 1'b1;
`endif
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and mux select registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
    end
  end

`ifdef PACKET_ARB_ROUND_ROBIN_EN
  // Round-robin pointer, advanced only when a packet completes.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`endif

  assign mux_in_sel_o = sel_q;
  assign locked_o     = (state_q == StLocked);

endmodule

// File: tb/tb_packet_arbiter_ctrl.sv
// Scoreboard bench for packet_arbiter_ctrl: source queues model the upstream
// buffers, expected transfers are queued by the stimulus and checked by a
// separate monitor whenever the DUT moves a flit downstream.
module tb_packet_arbiter_ctrl;

  localparam int unsigned N = 5;

  typedef struct packed {
    logic [2:0] sel;
    logic [1:0] fid;
  } xfer_t;

  logic           clk_i = 1'b0;
  logic           rst_i = 1'b1;
  logic [N-1:0]   vld_i = '0;
  logic [2*N-1:0] flit_id_i = '0;
  logic           out_rdy_i = 1'b1;
  logic [2:0]     mux_in_sel_o;
  logic [N-1:0]   in_rdy_o;
  logic           out_vld_o;
  logic           locked_o;

  logic [1:0] src_q [N][$];
  xfer_t      exp_q [$];
  logic       rdy_cfg = 1'b1;
  logic [N-1:0] stall_mask = '0;
  int n_checks = 0;
  int n_errors = 0;
  int xfer_cnt = 0;

  packet_arbiter_ctrl dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .vld_i        (vld_i),
    .flit_id_i    (flit_id_i),
    .out_rdy_i    (out_rdy_i),
    .mux_in_sel_o (mux_in_sel_o),
    .in_rdy_o     (in_rdy_o),
    .out_vld_o    (out_vld_o),
    .locked_o     (locked_o)
  );

  initial forever #5 clk_i = ~clk_i;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Upstream buffer model: pop what the DUT accepted, then present new heads.
  initial begin
    logic [N-1:0] pop_m;
    forever begin
      @(negedge clk_i);
      pop_m = in_rdy_o & vld_i;
      @(posedge clk_i);
      #1;
      for (int k = 0; k < N; k++) begin
        if (rst_i) src_q[k].delete();
        else if (pop_m[k] && src_q[k].size() != 0) void'(src_q[k].pop_front());
      end
      out_rdy_i = rdy_cfg;
      for (int k = 0; k < N; k++) begin
        vld_i[k] = (src_q[k].size() != 0) && !stall_mask[k];
        flit_id_i[k*2 +: 2] = (src_q[k].size() != 0) ? src_q[k][0] : 2'b00;
      end
    end
  end

  // Monitor: every downstream transfer must match the next expected one.
  initial begin
    xfer_t e;
    logic [1:0] got_fid;
    logic [N-1:0] got_rdy;
    forever begin
      @(negedge clk_i);
      if (!rst_i && out_vld_o && out_rdy_i) begin
        xfer_cnt++;
        n_checks++;
        got_fid = flit_id_i[int'(mux_in_sel_o)*2 +: 2];
        got_rdy = in_rdy_o;
        if (exp_q.size() == 0) begin
          n_errors++;
          $display("FAIL xfer_unexpected: got sel %0d fid %0d, required no transfer",
                   mux_in_sel_o, got_fid);
        end else begin
          e = exp_q.pop_front();
          if (mux_in_sel_o != e.sel || got_fid != e.fid || got_rdy != (N'(1) << e.sel)) begin
            n_errors++;
            $display("FAIL xfer: got sel %0d fid %0d in_rdy %b, required sel %0d fid %0d",
                     mux_in_sel_o, got_fid, got_rdy, e.sel, e.fid);
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic cyc();
    @(negedge clk_i);
  endtask

  task automatic push_pkt(input int src, input logic [1:0] ids [$]);
    xfer_t x;
    foreach (ids[i]) begin
      src_q[src].push_back(ids[i]);
      x.sel = 3'(src);
      x.fid = ids[i];
      exp_q.push_back(x);
    end
  endtask

  initial begin
    logic [1:0] ids [$];
    int seq [$];
    int base;

    // Reset state
    cyc();
    chk("rst_locked", locked_o, 0);
    chk("rst_sel", mux_in_sel_o, 0);
    chk("rst_in_rdy", in_rdy_o, 0);
    chk("rst_out_vld", out_vld_o, 0);
    @(posedge clk_i);
    #1 rst_i = 1'b0;

    // Single-flit grant on input 0
    cyc();
    ids = '{2'b11};
    push_pkt(0, ids);
    cyc();
    chk("t1_idle_locked", locked_o, 0);
    cyc();
    chk("t1_locked", locked_o, 1);
    chk("t1_sel", mux_in_sel_o, 0);
    chk("t1_in_rdy", in_rdy_o, 5'b00001);
    chk("t1_out_vld", out_vld_o, 1);
    cyc();
    chk("t1_back_locked", locked_o, 0);
    chk("t1_back_in_rdy", in_rdy_o, 0);
    chk("t1_back_out_vld", out_vld_o, 0);

    // Packet lock: input 3 four flits, input 4 waits with a head
    ids = '{2'b10, 2'b00, 2'b00, 2'b01};
    push_pkt(3, ids);
    ids = '{2'b11};
    push_pkt(4, ids);
    cyc();
    chk("t2_idle", locked_o, 0);
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("t2_locked", locked_o, 1);
      chk("t2_sel3", mux_in_sel_o, 3);
      chk("t2_rdy4_low", in_rdy_o[4], 0);
    end
    cyc();
    chk("t2_after_tail_idle", locked_o, 0);
    cyc();
    chk("t2_grant4_locked", locked_o, 1);
    chk("t2_grant4_sel", mux_in_sel_o, 4);
    chk("t2_grant4_rdy", in_rdy_o, 5'b10000);
    cyc();
    chk("t2_end_idle", locked_o, 0);

    // Downstream and source stalls mid-packet on input 1
    base = xfer_cnt;
    ids = '{2'b10, 2'b00, 2'b00, 2'b01};
    push_pkt(1, ids);
    cyc();
    chk("t3_idle", locked_o, 0);
    cyc();
    chk("t3_head_sel", mux_in_sel_o, 1);
    chk("t3_head_vld", out_vld_o, 1);
    rdy_cfg = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("t3_dstall_sel", mux_in_sel_o, 1);
      chk("t3_dstall_rdy", in_rdy_o, 0);
      chk("t3_dstall_vld", out_vld_o, 1);
      chk("t3_dstall_locked", locked_o, 1);
    end
    rdy_cfg = 1'b1;
    stall_mask = 5'b00010;
    for (int i = 0; i < 2; i++) begin
      cyc();
      chk("t3_sstall_sel", mux_in_sel_o, 1);
      chk("t3_sstall_rdy", in_rdy_o, 5'b00010);
      chk("t3_sstall_vld", out_vld_o, 0);
    end
    stall_mask = '0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("t3_resume_sel", mux_in_sel_o, 1);
      chk("t3_resume_vld", out_vld_o, 1);
    end
    cyc();
    chk("t3_end_idle", locked_o, 0);
    chk("t3_flit_count", xfer_cnt - base, 4);

    // Arbitration order from reset with all inputs offering single-flit packets
    rst_i = 1'b1;
    @(posedge clk_i);
    #1 rst_i = 1'b0;
    cyc();
`ifdef PACKET_ARB_ROUND_ROBIN_EN
    seq = '{0, 1, 2, 3, 4, 0, 1, 2, 3, 4};
`else
    seq = '{3, 3, 3, 4, 2, 1, 0};
`endif
    ids = '{2'b11};
    foreach (seq[i]) push_pkt(seq[i], ids);
    cyc();
    chk("t4_idle", locked_o, 0);
    foreach (seq[i]) begin
      cyc();
      chk("t4_grant_locked", locked_o, 1);
      chk("t4_grant_sel", mux_in_sel_o, seq[i]);
      cyc();
      chk("t4_gap_idle", locked_o, 0);
    end

    // Reset between body flits
    ids = '{2'b10, 2'b00, 2'b00, 2'b01};
    src_q[2].push_back(2'b10);
    src_q[2].push_back(2'b00);
    src_q[2].push_back(2'b00);
    src_q[2].push_back(2'b01);
    exp_q.push_back('{sel: 3'd2, fid: 2'b10});
    exp_q.push_back('{sel: 3'd2, fid: 2'b00});
    cyc();
    chk("t5_idle", locked_o, 0);
    cyc();
    chk("t5_head_sel", mux_in_sel_o, 2);
    cyc();
    chk("t5_body_sel", mux_in_sel_o, 2);
    rdy_cfg = 1'b0;
    cyc();
    chk("t5_pre_rst_vld", out_vld_o, 1);
    #2 rst_i = 1'b1;
    #1;
    chk("t5_async_locked", locked_o, 0);
    chk("t5_async_sel", mux_in_sel_o, 0);
    chk("t5_async_rdy", in_rdy_o, 0);
    chk("t5_async_vld", out_vld_o, 0);
    @(posedge clk_i);
    @(posedge clk_i);
    #1 rst_i = 1'b0;
    rdy_cfg = 1'b1;
    cyc();
    chk("t5_post_rst_idle", locked_o, 0);

    // A body flit in IDLE is never granted or popped
    src_q[2].push_back(2'b00);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("t6_body_locked", locked_o, 0);
      chk("t6_body_rdy", in_rdy_o, 0);
      chk("t6_body_vld", out_vld_o, 0);
    end
    chk("t6_body_still_queued", src_q[2].size(), 1);
    chk("all_expected_seen", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
